// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DIVISOR_115200 = 417;
  localparam int unsigned UART_DATA_BITS      = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus valid/ready byte port of the UART receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      serial_rxd;
  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;
  logic                      framing_err;
  logic                      overrun;

  modport master (
    input  serial_rxd,
    input  ready,
    output data,
    output valid,
    output framing_err,
    output overrun
  );

  modport slave (
    output serial_rxd,
    output ready,
    input  data,
    input  valid,
    input  framing_err,
    input  overrun
  );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RESET_VAL.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a clock divisor, byte out on valid/ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = UART_DIVISOR_115200
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam int unsigned HALF     = DIVISOR / 2;
  localparam int unsigned CW       = $clog2(DIVISOR);
  localparam int unsigned IW       = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIVISOR - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic                      w_sample;
  uart_state_e               r_state, w_state;
  logic [CW-1:0]             r_cnt, w_cnt;
  logic [IW-1:0]             r_idx, w_idx;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift;
  logic [UART_DATA_BITS-1:0] r_data, w_data;
  logic                      r_valid, w_valid;
  logic                      r_fe, w_fe;
  logic                      r_ov, w_ov;

  bit_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.serial_rxd),
    .o_q   (w_rx_s)
  );

  always_comb begin
    w_sample = (r_cnt == '0);
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_idx    = r_idx;
    w_shift  = r_shift;
    w_data   = r_data;
    w_valid  = r_valid;
    w_fe     = 1'b0;
    w_ov     = 1'b0;

    if (r_valid && bus.ready) w_valid = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state = START;
          w_cnt   = CNT_HALF;
        end
      end
      START: begin
        if (!w_sample) begin
          w_cnt = r_cnt - CW'(1);
        end else if (!w_rx_s) begin
          w_state = DATA;
          w_idx   = '0;
          w_cnt   = CNT_BIT;
        end else begin
          w_state = IDLE;
        end
      end
      DATA: begin
        if (!w_sample) begin
          w_cnt = r_cnt - CW'(1);
        end else begin
          w_shift = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
          w_cnt   = CNT_BIT;
          if (r_idx == LAST_BIT) w_state = STOP;
          else                   w_idx   = r_idx + IW'(1);
        end
      end
      STOP: begin
        if (!w_sample) begin
          w_cnt = r_cnt - CW'(1);
        end else if (w_rx_s) begin
          w_state = IDLE;
          // A same-edge handshake frees the slot, so the new byte is taken.
          if (r_valid && !bus.ready) begin
            w_ov = 1'b1;
          end else begin
            w_data  = r_shift;
            w_valid = 1'b1;
          end
        end else begin
          w_fe    = 1'b1;
          w_state = BREAK;
        end
      end
      BREAK: begin
        if (w_rx_s) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_fe    <= w_fe;
      r_ov    <= w_ov;
    end
  end

  assign bus.data        = r_data;
  assign bus.valid       = r_valid;
  assign bus.framing_err = r_fe;
  assign bus.overrun     = r_ov;

endmodule
